local_store_pipe: RTL and testbench

// - Parametrised quadword local store plus load/store pipeline for the odd pipe.
// - Replaces the fixed LS_address/LS_data/LS_wrt_en hookup with two request ports:

---
 rtl/local_store_pipe_pkg.sv | 21 ++
 rtl/ls_result_pipe.sv | 55 +++++
 rtl/local_store_pipe.sv | 100 ++++++++++
 tb/tb_local_store_pipe.sv | 234 +++++++++++++++++++++++
 4 files changed

// File: rtl/local_store_pipe_pkg.sv
// Shared constants and request type for the quadword local store and its load pipes.
// Widths here are the default configuration; the top re-derives them from its parameters.
package local_store_pipe_pkg;

   localparam int LS_DATA_W   = 128;
   localparam int LS_QW_BYTES = LS_DATA_W / 8;
   localparam int LS_ADDR_W   = 15;
   localparam int LS_LAT      = 6;
   localparam int LS_KILL_ST  = 2;
   localparam int LS_RT_W     = 7;

   typedef struct packed {
      logic                   valid;
      logic                   we;
      logic [LS_ADDR_W-1:0]   addr;
      logic [LS_DATA_W-1:0]   wdata;
      logic [LS_QW_BYTES-1:0] wmask;
      logic [LS_RT_W-1:0]     rt;
   } ls_req_t;

endpackage

// File: rtl/ls_result_pipe.sv
// LAT-stage valid/payload shift register; kill clears the KILL_ST youngest valids as they shift.
// Latency LAT cycles, one result per cycle, no backpressure.
module ls_result_pipe
   import local_store_pipe_pkg::*;
#(
   parameter int W       = LS_DATA_W,
   parameter int LAT     = LS_LAT,
   parameter int KILL_ST = 0
) (
   input  logic         clock_i,
   input  logic         reset_i,
   input  logic         in_vld_i,
   input  logic [W-1:0] in_dat_i,
   input  logic         kill_i,
   output logic         out_vld_o,
   output logic [W-1:0] out_dat_o
);

   logic [LAT-1:0] vld_q, vld_d;
   logic [W-1:0]   dat_q [LAT];
   logic [W-1:0]   dat_d [LAT];

   always_comb begin
      vld_d[0] = in_vld_i;
      dat_d[0] = in_dat_i;
      for (int k = 1; k < LAT; k++) begin
         vld_d[k] = vld_q[k-1];
         dat_d[k] = dat_q[k-1];
      end
      // Stage 0 already holds the request ignored by the flush; the rest are the younger loads.
      if (kill_i) begin
         for (int k = 0; k < KILL_ST; k++) begin
            vld_d[k] = 1'b0;
         end
      end
   end

   always_ff @(posedge clock_i or posedge reset_i) begin
      if (reset_i) begin
         vld_q <= '0;
         for (int k = 0; k < LAT; k++) begin
            dat_q[k] <= '0;
         end
      end else begin
         vld_q <= vld_d;
         for (int k = 0; k < LAT; k++) begin
            dat_q[k] <= dat_d[k];
         end
      end
   end

   assign out_vld_o = vld_q[LAT-1];
   assign out_dat_o = dat_q[LAT-1];

endmodule

// File: rtl/local_store_pipe.sv
// Quadword local store: port A (odd pipe, never stalled, byte-masked, flushable) and port B (valid/ready).
// Loads return LAT cycles after acceptance; B is stalled whenever A presents a live request.
module local_store_pipe
   import local_store_pipe_pkg::*;
#(
   parameter int DATA_W  = LS_DATA_W,
   parameter int ADDR_W  = LS_ADDR_W,
   parameter int LAT     = LS_LAT,
   parameter int KILL_ST = LS_KILL_ST
) (
   input  logic                  clock,
   input  logic                  reset,
   input  logic                  a_valid,
   input  logic                  a_we,
   input  logic [ADDR_W-1:0]     a_addr,
   input  logic [DATA_W-1:0]     a_wdata,
   input  logic [DATA_W/8-1:0]   a_wmask,
   input  logic [LS_RT_W-1:0]    a_rt,
   input  logic                  flush,
   output logic                  a_rd_valid,
   output logic [DATA_W-1:0]     a_rd_data,
   output logic [LS_RT_W-1:0]    a_rd_rt,
   input  logic                  b_valid,
   output logic                  b_ready,
   input  logic                  b_we,
   input  logic [ADDR_W-1:0]     b_addr,
   input  logic [DATA_W-1:0]     b_wdata,
   output logic                  b_rd_valid,
   output logic [DATA_W-1:0]     b_rd_data
);

   localparam int NB    = DATA_W / 8;
   localparam int OFF_W = $clog2(NB);
   localparam int IDX_W = ADDR_W - OFF_W;
   localparam int DEPTH = 1 << IDX_W;

   logic [DATA_W-1:0] mem [DEPTH];

   logic [IDX_W-1:0] a_idx, b_idx;
   logic a_go, a_ld, a_st, b_go, b_ld, b_st;
   logic [LS_RT_W+DATA_W-1:0] a_out_dat;
   logic unused_addr_bits;

   // Big-endian bit 0 of the address is its MSB, so the quadword index is the upper field.
   assign a_idx = a_addr[ADDR_W-1:OFF_W];
   assign b_idx = b_addr[ADDR_W-1:OFF_W];
   assign unused_addr_bits = ^{a_addr[OFF_W-1:0], b_addr[OFF_W-1:0]};

   assign a_go    = a_valid & ~flush & ~reset;
   assign a_ld    = a_go & ~a_we;
   assign a_st    = a_go & a_we;
   assign b_ready = ~reset & ~(a_valid & ~flush);
   assign b_go    = b_valid & b_ready;
   assign b_ld    = b_go & ~b_we;
   assign b_st    = b_go & b_we;

   // Mask bit i enables byte i, where byte 0 is the most significant byte of the quadword.
   always_ff @(posedge clock) begin
      if (a_st) begin
         for (int i = 0; i < NB; i++) begin
            if (a_wmask[i]) begin
               mem[a_idx][DATA_W-1-8*i -: 8] <= a_wdata[DATA_W-1-8*i -: 8];
            end
         end
      end else if (b_st) begin
         mem[b_idx] <= b_wdata;
      end
   end

   ls_result_pipe #(
      .W       (LS_RT_W + DATA_W),
      .LAT     (LAT),
      .KILL_ST (KILL_ST)
   ) u_a_pipe (
      .clock_i   (clock),
      .reset_i   (reset),
      .in_vld_i  (a_ld),
      .in_dat_i  ({a_rt, mem[a_idx]}),
      .kill_i    (flush),
      .out_vld_o (a_rd_valid),
      .out_dat_o (a_out_dat)
   );

   assign {a_rd_rt, a_rd_data} = a_out_dat;

   ls_result_pipe #(
      .W       (DATA_W),
      .LAT     (LAT),
      .KILL_ST (0)
   ) u_b_pipe (
      .clock_i   (clock),
      .reset_i   (reset),
      .in_vld_i  (b_ld),
      .in_dat_i  (mem[b_idx]),
      .kill_i    (1'b0),
      .out_vld_o (b_rd_valid),
      .out_dat_o (b_rd_data)
   );

endmodule

// File: tb/tb_local_store_pipe.sv
// Directed bench for local_store_pipe: reset, store/load, byte masks, arbitration, flush, wrap.
module tb_local_store_pipe;
   import local_store_pipe_pkg::*;

   localparam int DATA_W = 128;
   localparam int ADDR_W = 15;
   localparam int NB     = 16;

   logic              clock = 1'b0;
   logic              reset = 1'b0;
   logic              a_valid = 1'b0, a_we = 1'b0, flush = 1'b0;
   logic [ADDR_W-1:0] a_addr = '0;
   logic [DATA_W-1:0] a_wdata = '0;
   logic [NB-1:0]     a_wmask = '0;
   logic [6:0]        a_rt = '0;
   logic              a_rd_valid;
   logic [DATA_W-1:0] a_rd_data;
   logic [6:0]        a_rd_rt;
   logic              b_valid = 1'b0, b_we = 1'b0;
   logic              b_ready;
   logic [ADDR_W-1:0] b_addr = '0;
   logic [DATA_W-1:0] b_wdata = '0;
   logic              b_rd_valid;
   logic [DATA_W-1:0] b_rd_data;

   int errors = 0;
   int checks = 0;

   logic [DATA_W-1:0] D1, D2, D3, D4, D5, AA, M1, M2;

   local_store_pipe dut (
      .clock(clock), .reset(reset),
      .a_valid(a_valid), .a_we(a_we), .a_addr(a_addr), .a_wdata(a_wdata),
      .a_wmask(a_wmask), .a_rt(a_rt), .flush(flush),
      .a_rd_valid(a_rd_valid), .a_rd_data(a_rd_data), .a_rd_rt(a_rd_rt),
      .b_valid(b_valid), .b_ready(b_ready), .b_we(b_we), .b_addr(b_addr),
      .b_wdata(b_wdata), .b_rd_valid(b_rd_valid), .b_rd_data(b_rd_data)
   );

   always #5 clock = ~clock;

   task automatic step();
      @(posedge clock);
      #1;
   endtask

   task automatic a_issue(input logic we, input logic [ADDR_W-1:0] addr,
                          input logic [DATA_W-1:0] d, input logic [NB-1:0] m,
                          input logic [6:0] rt);
      a_valid = 1'b1; a_we = we; a_addr = addr; a_wdata = d; a_wmask = m; a_rt = rt;
      step();
      a_valid = 1'b0; a_we = 1'b0;
   endtask

   task automatic test_reset();
      b_valid = 1'b1;
      #1;
      checks++; if (a_rd_valid !== 1'b0) begin errors++; $display("FAIL reset_a_rd_valid got=%b want=0", a_rd_valid); end
      checks++; if (a_rd_data !== '0) begin errors++; $display("FAIL reset_a_rd_data got=%h want=0", a_rd_data); end
      checks++; if (a_rd_rt !== 7'd0) begin errors++; $display("FAIL reset_a_rd_rt got=%0d want=0", a_rd_rt); end
      checks++; if (b_rd_valid !== 1'b0) begin errors++; $display("FAIL reset_b_rd_valid got=%b want=0", b_rd_valid); end
      checks++; if (b_ready !== 1'b0) begin errors++; $display("FAIL reset_b_ready got=%b want=0", b_ready); end
      b_valid = 1'b0;
      step();
      reset = 1'b0;
      step();
   endtask

   task automatic test_store_load();
      a_issue(1'b1, 15'h0050, D1, 16'hFFFF, 7'd0);
      a_issue(1'b0, 15'h005C, '0, 16'h0000, 7'd9);
      repeat (4) step();
      checks++; if (a_rd_valid !== 1'b0) begin errors++; $display("FAIL sl_early_valid got=%b want=0", a_rd_valid); end
      step();
      checks++; if (a_rd_valid !== 1'b1) begin errors++; $display("FAIL sl_valid got=%b want=1", a_rd_valid); end
      checks++; if (a_rd_data !== D1) begin errors++; $display("FAIL sl_data got=%h want=%h", a_rd_data, D1); end
      checks++; if (a_rd_rt !== 7'd9) begin errors++; $display("FAIL sl_rt got=%0d want=9", a_rd_rt); end
      step();
      checks++; if (a_rd_valid !== 1'b0) begin errors++; $display("FAIL sl_store_no_result got=%b want=0", a_rd_valid); end
   endtask

   task automatic test_byte_mask();
      a_issue(1'b1, 15'h0100, AA, 16'hFFFF, 7'd0);
      a_issue(1'b1, 15'h0100, {16{8'h55}}, 16'h8001, 7'd0);
      a_issue(1'b1, 15'h0100, '0, 16'h0000, 7'd0);
      a_issue(1'b0, 15'h0100, '0, 16'h0000, 7'd3);
      repeat (5) step();
      checks++; if (a_rd_valid !== 1'b1 || a_rd_data !== M1)
         begin errors++; $display("FAIL mask_8001 got=%b/%h want=1/%h", a_rd_valid, a_rd_data, M1); end
      a_issue(1'b1, 15'h0100, {16{8'h11}}, 16'h0002, 7'd0);
      a_issue(1'b0, 15'h0108, '0, 16'h0000, 7'd4);
      repeat (5) step();
      checks++; if (a_rd_valid !== 1'b1 || a_rd_data !== M2)
         begin errors++; $display("FAIL mask_byte1 got=%b/%h want=1/%h", a_rd_valid, a_rd_data, M2); end
   endtask

   task automatic test_arbitration();
      b_valid = 1'b1; b_we = 1'b1; b_addr = 15'h0200; b_wdata = D2;
      #1;
      checks++; if (b_ready !== 1'b1) begin errors++; $display("FAIL arb_b_store_ready got=%b want=1", b_ready); end
      step();
      b_we = 1'b0;
      a_valid = 1'b1; a_we = 1'b0; a_addr = 15'h0200;
      for (int c = 0; c < 3; c++) begin
         a_rt = 7'(c + 1);
         #1;
         checks++; if (b_ready !== 1'b0) begin errors++; $display("FAIL arb_blocked_%0d got=%b want=0", c, b_ready); end
         step();
      end
      a_valid = 1'b0;
      #1;
      checks++; if (b_ready !== 1'b1) begin errors++; $display("FAIL arb_grant got=%b want=1", b_ready); end
      step();
      b_valid = 1'b0;
      for (int s = 2; s <= 6; s++) begin
         step();
         if (s == 3) begin
            checks++; if (a_rd_valid !== 1'b1 || a_rd_rt !== 7'd1 || a_rd_data !== D2)
               begin errors++; $display("FAIL arb_a_first got=%b/%0d/%h want=1/1/%h", a_rd_valid, a_rd_rt, a_rd_data, D2); end
         end
         if (s == 5) begin
            checks++; if (b_rd_valid !== 1'b0) begin errors++; $display("FAIL arb_b_early got=%b want=0", b_rd_valid); end
         end
      end
      checks++; if (b_rd_valid !== 1'b1 || b_rd_data !== D2)
         begin errors++; $display("FAIL arb_b_result got=%b/%h want=1/%h", b_rd_valid, b_rd_data, D2); end
   endtask

   task automatic test_flush();
      logic [6:0] got [8];
      int n = 0;
      int nb = 0;
      for (int i = 0; i < 8; i++) got[i] = 7'h7F;
      a_issue(1'b1, 15'h0400, D3, 16'hFFFF, 7'd0);
      a_valid = 1'b1; a_we = 1'b0; a_addr = 15'h0400;
      for (int c = 0; c < 5; c++) begin
         a_rt = 7'(c);
         if (c == 4) begin
            flush = 1'b1; b_valid = 1'b1; b_we = 1'b0; b_addr = 15'h0400;
            #1;
            checks++; if (b_ready !== 1'b1) begin errors++; $display("FAIL flush_b_ready got=%b want=1", b_ready); end
         end
         step();
      end
      a_valid = 1'b0; flush = 1'b0; b_valid = 1'b0;
      for (int s = 0; s < 10; s++) begin
         step();
         if (a_rd_valid) begin
            if (n < 8) got[n] = a_rd_rt;
            n++;
         end
         if (b_rd_valid) nb++;
      end
      checks++; if (n !== 3) begin errors++; $display("FAIL flush_count got=%0d want=3", n); end
      checks++; if (got[0] !== 7'd0 || got[1] !== 7'd1 || got[2] !== 7'd2)
         begin errors++; $display("FAIL flush_order got=%0d,%0d,%0d want=0,1,2", got[0], got[1], got[2]); end
      checks++; if (nb !== 1) begin errors++; $display("FAIL flush_b_results got=%0d want=1", nb); end
      flush = 1'b1;
      a_issue(1'b1, 15'h0400, ~D3, 16'hFFFF, 7'd0);
      flush = 1'b0;
      a_issue(1'b0, 15'h0400, '0, 16'h0000, 7'd5);
      repeat (5) step();
      checks++; if (a_rd_valid !== 1'b1 || a_rd_data !== D3)
         begin errors++; $display("FAIL flush_store_ignored got=%b/%h want=1/%h", a_rd_valid, a_rd_data, D3); end
   endtask

   task automatic test_wrap();
      a_issue(1'b1, 15'h7FF0, D4, 16'hFFFF, 7'd0);
      a_issue(1'b1, 15'h0000, D5, 16'hFFFF, 7'd0);
      a_issue(1'b0, 15'h7FF0, '0, 16'h0000, 7'd1);
      a_issue(1'b0, 15'h0000, '0, 16'h0000, 7'd2);
      repeat (4) step();
      checks++; if (a_rd_valid !== 1'b1 || a_rd_rt !== 7'd1 || a_rd_data !== D4)
         begin errors++; $display("FAIL wrap_last got=%b/%0d/%h want=1/1/%h", a_rd_valid, a_rd_rt, a_rd_data, D4); end
      step();
      checks++; if (a_rd_valid !== 1'b1 || a_rd_rt !== 7'd2 || a_rd_data !== D5)
         begin errors++; $display("FAIL wrap_first got=%b/%0d/%h want=1/2/%h", a_rd_valid, a_rd_rt, a_rd_data, D5); end
   endtask

   task automatic test_reset_inflight();
      int late = 0;
      a_issue(1'b0, 15'h0050, '0, 16'h0000, 7'd1);
      a_issue(1'b0, 15'h0050, '0, 16'h0000, 7'd2);
      a_issue(1'b0, 15'h0050, '0, 16'h0000, 7'd3);
      b_valid = 1'b1; b_we = 1'b0; b_addr = 15'h0100;
      step();
      b_valid = 1'b0;
      repeat (2) step();
      checks++; if (a_rd_valid !== 1'b1 || a_rd_data !== D1)
         begin errors++; $display("FAIL rst_pre_valid got=%b/%h want=1/%h", a_rd_valid, a_rd_data, D1); end
      #3 reset = 1'b1;
      #1;
      checks++; if (a_rd_valid !== 1'b0 || a_rd_data !== '0 || a_rd_rt !== 7'd0)
         begin errors++; $display("FAIL rst_async_clear got=%b/%h/%0d want=0/0/0", a_rd_valid, a_rd_data, a_rd_rt); end
      checks++; if (b_ready !== 1'b0) begin errors++; $display("FAIL rst_async_b_ready got=%b want=0", b_ready); end
      step();
      reset = 1'b0;
      for (int s = 0; s < 10; s++) begin
         step();
         if (a_rd_valid || b_rd_valid) late++;
      end
      checks++; if (late !== 0) begin errors++; $display("FAIL rst_late_valid got=%0d want=0", late); end
   endtask

   initial begin
      #20000;
      $display("FAIL watchdog expired");
      $display("Result: errors=%0d of %0d checks", errors + 1, checks + 1);
      $fatal(1);
   end

   initial begin
      D1 = 128'h0123456789ABCDEF0123456789ABCDEF;
      D2 = 128'hFEDCBA98765432100F1E2D3C4B5A6978;
      D3 = 128'h33333333444444445555555566666666;
      D4 = 128'hC0FFEE00C0FFEE00C0FFEE00C0FFEE01;
      D5 = 128'h0BADF00D0BADF00D0BADF00D0BADF00D;
      AA = {16{8'hAA}};
      M1 = {8'h55, {14{8'hAA}}, 8'h55};
      M2 = {8'h55, 8'h11, {13{8'hAA}}, 8'h55};
      #1 reset = 1'b1;
      #2;
      test_reset();
      test_store_load();
      test_byte_mask();
      test_arbitration();
      test_flush();
      test_wrap();
      test_reset_inflight();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
